// File: rtl/mem_arb_pkg.sv
// Shared types for the memory request arbiter.
// Source IDs, grant-state encoding and size codes.
package mem_arb_pkg;

  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;

  typedef enum logic [1:0] {
    GNT_FREE   = 2'd0,
    GNT_HOLD_I = 2'd1,
    GNT_HOLD_D = 2'd2
  } gnt_state_e;

endpackage

// File: rtl/mem_req_arbiter_id_fifo.sv
// id_fifo: DEPTH x 1-bit outstanding-source FIFO.
// Ports: clk, resetn, push/din, pop, head, full, empty.
module id_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head  = mem[rp];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem <= '0;
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= wp + AW'(1);
      end
      if (do_pop) begin
        rp <= rp + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates IF and MA requests onto one memory bus.
// Ports: inst_*, data_* requesters, bus_* interlayer, resp_err.
import mem_arb_pkg::*;

module mem_req_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [2:0]  inst_size,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [2:0]  data_size,
  input  logic [3:0]  data_wstrb,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        data_busy,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [2:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        resp_err
);

  localparam int CW = $clog2(DEPTH + 1);

  gnt_state_e    state;
  logic          gnt_i;
  logic          gnt_d;
  logic          greq;
  logic          accept;
  logic          pop;
  logic          head;
  logic          full;
  logic          empty;
  logic          d_inc;
  logic          d_dec;
  logic [CW-1:0] d_cnt;

  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    unique case (state)
      GNT_HOLD_I: gnt_i = 1'b1;
      GNT_HOLD_D: gnt_d = 1'b1;
      default: begin
        gnt_d = data_req;
        gnt_i = !data_req && inst_req;
      end
    endcase
  end

  assign greq = (gnt_d && data_req) || (gnt_i && inst_req);

  // Outputs are forced quiet while reset is held.
  assign bus_req = resetn && greq && !full;
  assign accept  = bus_req && bus_addr_ok;

  assign inst_addr_ok = accept && gnt_i;
  assign data_addr_ok = accept && gnt_d;

  always_comb begin
    bus_wr    = 1'b0;
    bus_addr  = inst_addr;
    bus_wdata = '0;
    bus_size  = inst_size;
    bus_wstrb = '0;
    unique case (1'b1)
      gnt_d: begin
        bus_wr    = data_wr;
        bus_addr  = data_addr;
        bus_wdata = data_wdata;
        bus_size  = data_size;
        bus_wstrb = data_wstrb;
      end
      default: ;
    endcase
  end

  id_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (accept),
    .din    (gnt_d ? SRC_D : SRC_I),
    .pop    (pop),
    .head   (head),
    .full   (full),
    .empty  (empty)
  );

  assign pop          = bus_data_ok && !empty;
  assign inst_data_ok = pop && (head == SRC_I);
  assign data_data_ok = pop && (head == SRC_D);
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

  assign d_inc     = accept && gnt_d;
  assign d_dec     = data_data_ok;
  assign data_busy = (d_cnt != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= GNT_FREE;
      d_cnt    <= '0;
      resp_err <= 1'b0;
    end else begin
      unique case (state)
        GNT_HOLD_I,
        GNT_HOLD_D: begin
          if (accept) state <= GNT_FREE;
        end
        default: begin
          if ((gnt_i || gnt_d) && !accept)
            state <= gnt_d ? GNT_HOLD_D : GNT_HOLD_I;
        end
      endcase
      case ({d_inc, d_dec})
        2'b10:   d_cnt <= d_cnt + CW'(1);
        2'b01:   d_cnt <= d_cnt - CW'(1);
        default: d_cnt <= d_cnt;
      endcase
      if (bus_data_ok && empty) resp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter.
// Directed plan cases, then randomized traffic.
import mem_arb_pkg::*;

module tb_mem_req_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [2:0]  inst_size;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [2:0]  data_size;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        data_busy;
  logic        bus_req;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [2:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic        resp_err;

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_size    (inst_size),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .data_busy    (data_busy),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_size     (bus_size),
    .bus_wstrb    (bus_wstrb),
    .bus_addr_ok  (bus_addr_ok),
    .bus_data_ok  (bus_data_ok),
    .bus_rdata    (bus_rdata),
    .resp_err     (resp_err)
  );

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: outstanding sources in order, held source.
  int mq[$];
  int sb[$];
  int held   = -1;
  bit rerr_m = 1'b0;
  bit mon_en = 1'b0;
  int mon_s;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle(
    input  logic        ir,
    input  logic [31:0] ia,
    input  logic [2:0]  isz,
    input  logic        dr,
    input  logic        dw,
    input  logic [31:0] da,
    input  logic [31:0] dwd,
    input  logic [2:0]  dsz,
    input  logic [3:0]  dst,
    input  logic        ao,
    input  logic        dok,
    input  logic [31:0] rd,
    output bit          ai,
    output bit          ad
  );
    int          g;
    int          busy;
    bit          greq;
    bit          full;
    bit          ereq;
    bit          eacc;
    logic [31:0] ea;
    logic [31:0] ewd;
    logic        ew;
    logic [2:0]  esz;
    logic [3:0]  es;
    inst_req    = ir;
    inst_addr   = ia;
    inst_size   = isz;
    data_req    = dr;
    data_wr     = dw;
    data_addr   = da;
    data_wdata  = dwd;
    data_size   = dsz;
    data_wstrb  = dst;
    bus_addr_ok = ao;
    bus_data_ok = dok;
    bus_rdata   = rd;
    if (held >= 0) g = held;
    else if (dr)   g = 1;
    else if (ir)   g = 0;
    else           g = -1;
    full = (mq.size() == DEPTH);
    greq = (g == 1 && dr) || (g == 0 && ir);
    ereq = greq && !full;
    eacc = ereq && ao;
    busy = 0;
    foreach (mq[k]) if (mq[k] == 1) busy++;
    if (g == 1) begin
      ea = da; ewd = dwd; ew = dw; esz = dsz; es = dst;
    end else begin
      ea = ia; ewd = '0; ew = 1'b0; esz = isz; es = '0;
    end
    #2;
    chk("bus_req", bus_req, ereq);
    chk("inst_addr_ok", inst_addr_ok, eacc && g == 0);
    chk("data_addr_ok", data_addr_ok, eacc && g == 1);
    chk("bus_addr_wdata", {bus_addr, bus_wdata}, {ea, ewd});
    chk("bus_ctl", {bus_wr, bus_size, bus_wstrb}, {ew, esz, es});
    chk("data_busy", data_busy, busy != 0);
    chk("resp_err", resp_err, rerr_m);
    @(posedge clk);
    if (dok) begin
      if (mq.size() > 0) void'(mq.pop_front());
      else rerr_m = 1'b1;
    end
    if (eacc) begin
      mq.push_back(g);
      sb.push_back(g);
    end
    held = (g >= 0 && !eacc) ? g : -1;
    ai = eacc && g == 0;
    ad = eacc && g == 1;
    #1;
  endtask

  task automatic step(input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dw,
                      input logic [31:0] da, input logic ao,
                      input logic dok, input logic [31:0] rd);
    bit ai;
    bit ad;
    cycle(ir, ia, SIZE_W, dr, dw, da, ~da, SIZE_W,
          dw ? 4'hF : 4'h0, ao, dok, rd, ai, ad);
  endtask

  task automatic do_reset(input logic ir);
    inst_req    = ir;
    data_req    = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = 32'hA5A5_0F0F;
    #1;
    resetn = 1'b0;
    #1;
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_data_busy", data_busy, 1'b0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
    chk("rst_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
    chk("rst_rdata", {inst_rdata, data_rdata}, {bus_rdata, bus_rdata});
    mq.delete();
    sb.delete();
    held   = -1;
    rerr_m = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  // Response monitor: routes each bus response against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus_data_ok && sb.size() > 0) begin
        mon_s = sb.pop_front();
        chk("resp_route", {inst_data_ok, data_data_ok},
            (mon_s == 1) ? 2'b01 : 2'b10);
        chk("resp_rdata", (mon_s == 1) ? data_rdata : inst_rdata,
            bus_rdata);
      end else begin
        chk("no_resp", {inst_data_ok, data_data_ok}, 2'b00);
      end
    end
  end

  initial begin
    bit          ip;
    bit          dp;
    bit          ai;
    bit          ad;
    bit          ao;
    bit          dok;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] dwd;
    logic        dw;
    logic [2:0]  isz;
    logic [2:0]  dsz;
    logic [3:0]  dst;

    resetn      = 1'b0;
    inst_req    = 1'b0;
    inst_addr   = '0;
    inst_size   = '0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_addr   = '0;
    data_wdata  = '0;
    data_size   = '0;
    data_wstrb  = '0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = '0;
    do_reset(1'b0);
    mon_en = 1'b1;

    // Idle IF fetch, response two cycles after accept.
    step(1, 32'hBFC0_0000, 0, 0, 32'h0, 1, 0, 32'h0);
    step(0, 32'hBFC0_0000, 0, 0, 32'h0, 0, 0, 32'h0);
    step(0, 32'hBFC0_0000, 0, 0, 32'h0, 0, 1, 32'h3C08_0001);

    // Simultaneous requests: D first, then I.
    step(1, 32'hBFC0_0004, 1, 1, 32'h8000_1004, 1, 0, 32'h0);
    step(1, 32'hBFC0_0004, 0, 0, 32'h8000_1004, 1, 0, 32'h0);
    step(0, 32'hBFC0_0004, 0, 0, 32'h0, 0, 1, 32'h1111_2222);
    step(0, 32'hBFC0_0004, 0, 0, 32'h0, 0, 1, 32'h3333_4444);

    // Held IF grant while data_req rises.
    step(1, 32'hBFC0_0008, 0, 0, 32'h8000_2000, 0, 0, 32'h0);
    step(1, 32'hBFC0_0008, 1, 0, 32'h8000_2000, 0, 0, 32'h0);
    step(1, 32'hBFC0_0008, 1, 0, 32'h8000_2000, 0, 0, 32'h0);
    step(1, 32'hBFC0_0008, 1, 0, 32'h8000_2000, 1, 0, 32'h0);
    step(0, 32'hBFC0_0008, 1, 0, 32'h8000_2000, 1, 0, 32'h0);
    step(0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h5555_6666);
    step(0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h7777_8888);

    // Full FIFO blocks bus_req, even in the popping cycle.
    step(0, 32'h0, 1, 1, 32'h8000_3000, 1, 0, 32'h0);
    step(0, 32'h0, 1, 0, 32'h8000_3004, 1, 0, 32'h0);
    step(0, 32'h0, 1, 0, 32'h8000_3008, 1, 0, 32'h0);
    step(0, 32'h0, 1, 0, 32'h8000_3008, 1, 1, 32'h9999_0000);
    step(0, 32'h0, 1, 0, 32'h8000_3008, 1, 0, 32'h0);
    step(0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h9999_0001);
    step(0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h9999_0002);

    // Stray response sets the sticky error.
    step(0, 32'h0, 0, 0, 32'h0, 0, 1, 32'hDEAD_BEEF);
    step(0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);

    // Reset with one D outstanding and IF held.
    step(0, 32'h0, 1, 0, 32'h8000_4000, 1, 0, 32'h0);
    step(1, 32'hBFC0_0010, 0, 0, 32'h0, 0, 0, 32'h0);
    do_reset(1'b1);
    step(1, 32'hBFC0_0010, 1, 0, 32'h8000_5000, 0, 0, 32'h0);
    step(1, 32'hBFC0_0010, 1, 0, 32'h8000_5000, 1, 0, 32'h0);
    step(1, 32'hBFC0_0010, 0, 0, 32'h0, 1, 0, 32'h0);
    step(0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h0BAD_F00D);
    step(0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h600D_F00D);

    // Randomized traffic with requesters holding until accepted.
    ip  = 1'b0;
    dp  = 1'b0;
    ia  = '0;
    da  = '0;
    dwd = '0;
    dw  = 1'b0;
    isz = SIZE_W;
    dsz = SIZE_W;
    dst = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!ip && $urandom_range(0, 2) == 0) begin
        ip  = 1'b1;
        ia  = $urandom() & 32'hFFFF_FFFC;
        isz = 3'($urandom_range(0, 2));
      end
      if (!dp && $urandom_range(0, 2) == 0) begin
        dp  = 1'b1;
        da  = $urandom();
        dw  = 1'($urandom_range(0, 1));
        dwd = $urandom();
        dsz = 3'($urandom_range(0, 2));
        dst = 4'($urandom_range(0, 15));
      end
      ao  = ($urandom_range(0, 3) != 0);
      dok = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
      if (mq.size() == 0 && $urandom_range(0, 299) == 0) dok = 1'b1;
      cycle(ip, ia, isz, dp, dw, da, dwd, dsz, dst, ao, dok,
            $urandom(), ai, ad);
      if (ai) ip = 1'b0;
      if (ad) dp = 1'b0;
    end

    for (int n = 0; n < 8; n++) begin
      cycle(1'b0, ia, isz, 1'b0, dw, da, dwd, dsz, dst, 1'b0,
            mq.size() > 0, $urandom(), ai, ad);
    end

    #2;
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Arbitrates the single memory request interface between the instruction-fetch requester (IF) and the data requester (MA load/store path). Grants one request per accept cycle, gives data priority, holds a grant until the address phase is accepted, and routes in-order responses back using a small outstanding-ID FIFO. Sits between the pipeline stages and the interlayer/bus bridge, and supplies the `data_busy` back-pressure that MA uses to stall loads.

## Interface
- `DEPTH`, 2: maximum outstanding accepted transactions; power of two, at least 2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `resetn`  in  1  asynchronous active-low reset.
- `inst_req`  in  1  IF read request; held stable until `inst_addr_ok`.
- `inst_addr`  in  32  IF word address.
- `inst_size`  in  3  IF size code (0 = byte, 1 = half, 2 = word).
- `inst_addr_ok`  out  1  IF request accepted this cycle.
- `inst_data_ok`  out  1  IF read data valid this cycle.
- `inst_rdata`  out  32  IF read data.
- `data_req`, `data_wr`  in  1 each  MA request; `data_wr` = 1 means store.
- `data_addr`, `data_wdata`  in  32 each  MA address and store data.
- `data_size`  in  3  MA size code.
- `data_wstrb`  in  4  MA byte strobes.
- `data_addr_ok`, `data_data_ok`  out  1 each  MA accept and response strobes.
- `data_rdata`  out  32  MA load data.
- `data_busy`  out  1  at least one accepted MA transaction is awaiting `data_ok`.
- `bus_req`, `bus_wr`  out  1 each  request to the interlayer.
- `bus_addr`, `bus_wdata`  out  32 each  interlayer address and write data.
- `bus_size`  out  3  interlayer size code.
- `bus_wstrb`  out  4  interlayer byte strobes.
- `bus_addr_ok`, `bus_data_ok`  in  1 each  interlayer accept and response strobes.
- `bus_rdata`  in  32  interlayer read data.
- `resp_err`  out  1  sticky: `bus_data_ok` arrived with no transaction outstanding.

## Operation
- Grant state is `FREE`, `HOLD_I` or `HOLD_D`.
- **In `FREE`:**
  - If `data_req` is high, grant D.
  - Otherwise, if `inst_req` is high, grant I.
  - If the grant is not accepted this cycle (`bus_addr_ok` = 0), move to `HOLD_D` or `HOLD_I` accordingly.
- **In `HOLD_x`:** grant x unconditionally. Return to `FREE` on `bus_req && bus_addr_ok`. The other requester is never granted while the grant is held.
- **Bus drive:**
  - `bus_*` fields mux from the granted requester.
  - For an IF grant: `bus_wr` = 0, `bus_wstrb` = 0, `bus_wdata` = 0.
  - `bus_req` = (granted req) && !fifo_full.
- **Accept:** `x_addr_ok` = `bus_addr_ok && bus_req && grant==x`.
- **FIFO push:** on accept, push the source ID (0 = I, 1 = D) into a DEPTH-entry FIFO.
- **FIFO pop:**
  - On `bus_data_ok`, pop the head and route the response: `x_data_ok` = `bus_data_ok && head==x`.
  - `inst_rdata` = `data_rdata` = `bus_rdata`, passed through unregistered.
- **data_busy:** count of D entries in the FIFO is non-zero. Maintain it as a separate counter of width clog2(DEPTH+1).
- **Full FIFO:** `bus_req` is forced to 0, even if a pop occurs in the same cycle. The grant state is unaffected.
- **Simultaneous push and pop (not full):** occupancy is unchanged and both pointers advance.
- **Empty FIFO with `bus_data_ok`:**
  - No `x_data_ok` is asserted and the pointers do not move.
  - `resp_err` is set and held until reset.
- **Pointer wrap:** pointers are log2(DEPTH) bits and wrap naturally. Occupancy is a clog2(DEPTH+1)-bit counter.
- **Reset (async, mid-transaction allowed):**
  - State returns to `FREE`; the FIFO, counters and `resp_err` clear.
  - In-flight responses are discarded by the system reset; no recovery is attempted.

## Timing
- **Reset values:**
  - All outputs are 0 except pass-through data.
  - `inst_rdata` and `data_rdata` follow `bus_rdata`.
  - `bus_addr`, `bus_size` and `bus_wdata` show the IF fields (0 for `bus_wdata`) while no request is granted.
- **Request path:** fully combinational, requester to `bus_req`/`bus_addr` and `bus_addr_ok` to `x_addr_ok`. Zero-cycle accept when the interlayer accepts immediately.
- **Response path:** combinational, `bus_data_ok` to `x_data_ok`. A response may return in the cycle after accept at the earliest.
- **FIFO timing:** FIFO and `data_busy` update at the clock edge after the accept or response.
- **Requester rules:**
  - Requesters must hold `req` and all fields stable until `addr_ok`.
  - The arbiter never drops a granted, unaccepted request.
- **Starvation:** IF can starve under continuous `data_req`. This is accepted, because MA is older in program order.

## Structure
- Shared package `mem_arb_pkg`:
  - Source-ID constants `SRC_I` and `SRC_D`.
  - Grant-state encoding.
  - Size codes: `SIZE_B` = 0, `SIZE_H` = 1, `SIZE_W` = 2.
- One sub-module, `id_fifo`: parameterised DEPTH×1-bit synchronous FIFO with push, pop, head, full, empty and async active-low reset.

## Test plan
- **Idle IF fetch:** `inst_req` with addr 0xBFC00000 and `bus_addr_ok` = 1 → `inst_addr_ok` the same cycle; `bus_data_ok` 2 cycles later with rdata 0x3C080001 → `inst_data_ok` = 1 and `inst_rdata` = 0x3C080001; `data_data_ok` stays 0.
- **Simultaneous requests:** `inst_req` and `data_req` (store, addr 0x80001004, wstrb 0xF) → D granted first, I the next cycle. Responses arrive in order D then I, and `data_busy` drops after the D response.
- **Held grant:** IF granted with `bus_addr_ok` = 0 for 3 cycles while `data_req` rises → `bus_addr` stays the IF address until accept; D is then accepted the following cycle.
- **FIFO full:** 2 accepts without a response → `bus_req` = 0 even though `data_req` = 1. The cycle after the first `bus_data_ok`, `bus_req` returns to 1.
- **Stray response:** `bus_data_ok` with an empty FIFO → no `x_data_ok`, and `resp_err` = 1 until reset.
- **Reset mid-operation:** assert `resetn` = 0 with 1 outstanding D entry and state `HOLD_I` → `data_busy`, `bus_req` and `resp_err` go to 0 immediately, and the state is `FREE` after release.
